ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte to the keyboard (LED set 0xED, reset 0xFF, and so on) using the PS/2 host-request protocol. It sits beside the existing PS/2 scan-code receiver and shares the same ps2_clk/ps2_data pins through open-drain enables. While `busy` is high, the receiver must ignore the bus.

Parameters:
- INHIBIT_CYCLES, 5000, clk cycles that ps2_clk is held low before the request (at least 100 us at the clk rate).
- TIMEOUT_CYCLES, 750000, clk cycles allowed from request to ack before aborting (15 ms).
- SYNC_STAGES, 3, synchroniser depth for ps2_clk and ps2_data.

Ports:
- clk  in  1  system clock; only clock domain.
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin value; asynchronous.
- ps2_data  in  1  raw PS/2 data pin value; asynchronous.
- ps2_clk_oe  out  1  1 = drive the ps2_clk pin low; 0 = release it.
- ps2_data_oe  out  1  1 = drive the ps2_data pin low; 0 = release it.
- tx_data  in  8  command byte to send.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high in IDLE; a transfer is accepted when tx_valid and tx_ready are both high.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the device acked and both lines have returned high.
- err  out  1  one-cycle pulse on no-ack or timeout.

Behaviour:
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, busy=0, done=0, err=0, state=IDLE. Synchroniser flops reset to 1.
- Synchronisation: both pins pass through SYNC_STAGES flops. `fall` = previous synchronised clk is 1 and current synchronised clk is 0. Only the synchronised values are used internally.
- Accept: in IDLE, tx_valid&tx_ready latches tx_data and par = ~^tx_data (odd parity). The shift register holds {stop=1, par, d7..d0}, LSB first. State goes to INHIBIT.
- INHIBIT: clk_oe=1 for exactly INHIBIT_CYCLES cycles, then go to REQ.
- REQ (1 cycle): clk_oe=1, data_oe=1 (start bit 0). Next state is SHIFT with clk_oe=0. The timeout counter clears here.
- SHIFT: data_oe stays 1 (start bit) until the first fall. On fall k (k=1..10), drive bit k-1 of the shift register with data_oe = ~bit. Bits are d0..d7, parity, then stop; the stop bit releases data. The 4-bit counter counts falls; after fall 10 the state goes to ACK.
- ACK: on the next fall, sample the synchronised data. 0 = ack, go to WAIT_IDLE. 1 = no ack, pulse err and go to IDLE.
- WAIT_IDLE: wait until synchronised clk and data are both 1, then pulse done and go to IDLE.
- Timeout: the counter runs in SHIFT, ACK and WAIT_IDLE. When it reaches TIMEOUT_CYCLES-1: pulse err, force both oe to 0, go to IDLE.
- Outputs are registered. done and err are never high in the same cycle. tx_valid is ignored while busy.
- Reset mid-transfer releases both lines on the next clk edge.
- A fall during INHIBIT or REQ (device glitch) is ignored.

Decomposition:
- Package ps2_pkg holds:
  - state enum IDLE/INHIBIT/REQ/SHIFT/ACK/WAIT_IDLE;
  - constant PS2_FRAME_BITS=10 (data, parity, stop);
  - odd-parity function.
- One sub-module, ps2_sync_edge: the synchroniser plus falling-edge detector, with outputs clk_s, data_s, fall. The existing receiver can reuse it.

Test Plan:
1. Send 0xED with a device model clocking at 12.5 kHz that acks:
   - ps2_clk_oe high for exactly 5000 cycles;
   - the device samples start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1;
   - done pulses once; err stays 0.
2. Send 0xFF then 0x01 back-to-back with tx_valid held high:
   - the second byte is accepted only after done;
   - parity bits are 1 and 0 respectively.
3. Device model never pulls data low at fall 11 → err pulses once, no done, both oe=0, tx_ready=1 the next cycle.
4. Device model never clocks after REQ → err pulses exactly TIMEOUT_CYCLES cycles after REQ, and both lines are released.
5. Assert reset at fall 5 of a 0xA5 transfer → the next cycle has both oe=0, busy=0, tx_ready=1. A fresh 0x3C then completes with done.
6. Inject a ps2_clk low glitch during INHIBIT and toggle tx_valid while busy → the frame is unaffected and no extra transfer is accepted.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 types and helpers.
// Used by the host transmitter and the scan-code receiver.
package ps2_pkg;

  typedef logic [2:0] ps2_state_t;

  localparam ps2_state_t IDLE      = 3'd0;
  localparam ps2_state_t INHIBIT   = 3'd1;
  localparam ps2_state_t REQ       = 3'd2;
  localparam ps2_state_t SHIFT     = 3'd3;
  localparam ps2_state_t ACK       = 3'd4;
  localparam ps2_state_t WAIT_IDLE = 3'd5;

  // data byte, parity, stop
  localparam int PS2_FRAME_BITS = 10;

  function automatic logic odd_par(
    input logic [7:0] d
  );
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// PS/2 pin synchroniser with falling-edge detect on the clock line.
// Flops reset to 1 so an idle bus reads high.
module ps2_sync_edge #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_s,
  output logic data_s,
  output logic fall
);

  logic [STAGES-1:0] clk_sr;
  logic [STAGES-1:0] data_sr;
  logic              clk_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sr  <= '1;
      data_sr <= '1;
      clk_q   <= 1'b1;
    end else begin
      clk_sr  <= {clk_sr[STAGES-2:0], ps2_clk};
      data_sr <= {data_sr[STAGES-2:0], ps2_data};
      clk_q   <= clk_sr[STAGES-1];
    end
  end

  assign clk_s  = clk_sr[STAGES-1];
  assign data_s = data_sr[STAGES-1];
  assign fall   = clk_q & ~clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Drives the shared pins through open-drain enables.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // REQ is the last clock-low cycle, so INHIBIT runs one short
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 2);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    BIT_LAST = 4'(PS2_FRAME_BITS - 1);

  ps2_state_t                state;
  logic [PS2_FRAME_BITS-1:0] shreg;
  logic [3:0]                bit_cnt;
  logic [IW-1:0]             inh_cnt;
  logic [TW-1:0]             to_cnt;
  logic                      clk_s;
  logic                      data_s;
  logic                      fall;
  logic                      in_xfer;

  ps2_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .clk_s    (clk_s),
    .data_s   (data_s),
    .fall     (fall)
  );

  assign tx_ready = (state == IDLE);
  assign busy     = ~tx_ready;
  assign in_xfer  = (state == SHIFT) ||
                    (state == ACK) ||
                    (state == WAIT_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (in_xfer && to_cnt == TO_LAST) begin
        err         <= 1'b1;
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        state       <= IDLE;
      end else begin
        if (in_xfer) to_cnt <= to_cnt + TW'(1);
        case (state)
          IDLE: begin
            if (tx_valid && tx_ready) begin
              shreg      <= {1'b1, odd_par(tx_data), tx_data};
              inh_cnt    <= '0;
              ps2_clk_oe <= 1'b1;
              state      <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (inh_cnt == INH_LAST) begin
              ps2_data_oe <= 1'b1;
              to_cnt      <= '0;
              state       <= REQ;
            end else begin
              inh_cnt <= inh_cnt + IW'(1);
            end
          end
          REQ: begin
            ps2_clk_oe <= 1'b0;
            bit_cnt    <= '0;
            to_cnt     <= to_cnt + TW'(1);
            state      <= SHIFT;
          end
          SHIFT: begin
            if (fall) begin
              ps2_data_oe <= ~shreg[0];
              shreg   <= {1'b0, shreg[PS2_FRAME_BITS-1:1]};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == BIT_LAST) state <= ACK;
            end
          end
          ACK: begin
            if (fall) begin
              if (!data_s) begin
                state <= WAIT_IDLE;
              end else begin
                err   <= 1'b1;
                state <= IDLE;
              end
            end
          end
          WAIT_IDLE: begin
            if (clk_s && data_s) begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model.
// Pins are modelled as wired-AND of host and device pull-downs.
module tb_ps2_host_tx;

  localparam int INH  = 60;
  localparam int TO   = 1500;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       glitch_hi = 1'b0;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_done = 0;
  int n_err = 0;
  int acc_cyc = 0;
  int done_cyc = 0;
  int run = 0;
  int last_run = 0;
  bit both = 1'b0;

  assign ps2_clk  = glitch_hi | ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO),
    .SYNC_STAGES    (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (done) begin
      n_done = n_done + 1;
      done_cyc = cyc;
    end
    if (err) n_err = n_err + 1;
    if (done && err) both = 1'b1;
    if (ps2_clk_oe) begin
      run = run + 1;
    end else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end

  always @(posedge clk) begin
    if (tx_valid && tx_ready && !reset) begin
      n_acc = n_acc + 1;
      acc_cyc = cyc;
    end
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    step;
    tx_valid = 1'b0;
  endtask

  task automatic wait_out(input bit pick_err, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      step;
      ok = pick_err ? err : done;
    end
  endtask

  // Device side: waits for the request, clocks 10 bits, then the ack slot.
  task automatic dev_frame(input bit ack, input int stop_fall, output logic [10:0] got);
    int n;
    got = '1;
    n = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && n < 500) begin
      step;
      n++;
    end
    chk("req_seen", 32'(n < 500), 32'd1);
    repeat (HALF) step;
    got[0] = ps2_data;
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) step;
      if (k == stop_fall) return;
      got[k] = ps2_data;
      dev_clk_low = 1'b0;
      repeat (HALF) step;
    end
    if (ack) dev_data_low = 1'b1;
    repeat (HALF / 2) step;
    dev_clk_low = 1'b1;
    repeat (HALF) step;
    dev_clk_low = 1'b0;
    repeat (HALF) step;
    dev_data_low = 1'b0;
  endtask

  initial begin
    logic [10:0] got;
    logic [10:0] got2;
    bit ok;
    int n, a0, d0, e0, r;

    reset = 1'b1;
    repeat (3) step;
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    step;

    d0 = n_done;
    e0 = n_err;
    send(8'hED);
    chk("t1_busy", busy, 1);
    dev_frame(1'b1, 0, got);
    wait_out(1'b0, 200, ok);
    repeat (5) step;
    chk("t1_done_seen", ok, 1);
    chk("t1_frame", got, 11'h7DA);
    chk("t1_inhibit_len", last_run, INH);
    chk("t1_done_cnt", n_done - d0, 1);
    chk("t1_err_cnt", n_err - e0, 0);

    a0 = n_acc;
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    n = 0;
    while (n_acc == a0 && n < 100) begin
      step;
      n++;
    end
    tx_data = 8'h01;
    dev_frame(1'b1, 0, got);
    n = 0;
    while (n_acc < a0 + 2 && n < 200) begin
      step;
      n++;
    end
    tx_valid = 1'b0;
    chk("t2_acc_at_done", acc_cyc, done_cyc);
    dev_frame(1'b1, 0, got2);
    wait_out(1'b0, 200, ok);
    repeat (5) step;
    chk("t2_done2_seen", ok, 1);
    chk("t2_frame_ff", got, 11'h7FE);
    chk("t2_par_ff", got[9], 1);
    chk("t2_frame_01", got2, 11'h402);
    chk("t2_par_01", got2[9], 0);
    chk("t2_acc_cnt", n_acc - a0, 2);

    d0 = n_done;
    e0 = n_err;
    send(8'h5A);
    fork
      dev_frame(1'b0, 0, got);
      begin
        wait_out(1'b1, 3000, ok);
        step;
        chk("t3_clk_oe", ps2_clk_oe, 0);
        chk("t3_data_oe", ps2_data_oe, 0);
        chk("t3_tx_ready", tx_ready, 1);
      end
    join
    repeat (5) step;
    chk("t3_err_seen", ok, 1);
    chk("t3_err_cnt", n_err - e0, 1);
    chk("t3_done_cnt", n_done - d0, 0);

    e0 = n_err;
    send(8'h77);
    n = 0;
    while (!(ps2_clk_oe && ps2_data_oe) && n < 500) begin
      step;
      n++;
    end
    r = cyc;
    wait_out(1'b1, TO + 50, ok);
    chk("t4_err_seen", ok, 1);
    chk("t4_latency", cyc - r, TO);
    chk("t4_clk_oe", ps2_clk_oe, 0);
    chk("t4_data_oe", ps2_data_oe, 0);
    repeat (5) step;
    chk("t4_err_cnt", n_err - e0, 1);

    send(8'hA5);
    dev_frame(1'b1, 5, got);
    reset = 1'b1;
    step;
    chk("t5_clk_oe", ps2_clk_oe, 0);
    chk("t5_data_oe", ps2_data_oe, 0);
    chk("t5_busy", busy, 0);
    chk("t5_tx_ready", tx_ready, 1);
    reset = 1'b0;
    dev_clk_low = 1'b0;
    repeat (HALF) step;
    d0 = n_done;
    send(8'h3C);
    dev_frame(1'b1, 0, got);
    wait_out(1'b0, 200, ok);
    repeat (5) step;
    chk("t5_frame_3c", got, 11'h678);
    chk("t5_done_cnt", n_done - d0, 1);

    a0 = n_acc;
    d0 = n_done;
    send(8'h12);
    tx_data = 8'h55;
    repeat (8) step;
    glitch_hi = 1'b1;
    repeat (6) step;
    glitch_hi = 1'b0;
    tx_valid = 1'b1;
    step;
    tx_valid = 1'b0;
    step;
    tx_valid = 1'b1;
    repeat (3) step;
    tx_valid = 1'b0;
    dev_frame(1'b1, 0, got);
    wait_out(1'b0, 200, ok);
    repeat (5) step;
    chk("t6_frame_12", got, 11'h624);
    chk("t6_inhibit_len", last_run, INH);
    chk("t6_acc_cnt", n_acc - a0, 1);
    chk("t6_done_cnt", n_done - d0, 1);

    chk("done_err_overlap", both, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
